serial_parity_frame_checker: RTL
================================

# serial_parity_frame_checker

Serial receive-side frame checker that generalises the single-bit parity detector. It deframes a start/data/parity/stop serial stream of parametrised data width and parity mode (even or odd), then presents each received word with parity and framing status. A saturating error counter supports link monitoring. It sits directly behind the serial input synchroniser and ahead of any word-level consumer.

## Interface
- DATA_BITS, 8, data bits per frame (1..32)
- ODD_PARITY, 0, 0 = even parity (data ^ parity bit = 0), 1 = odd parity (= 1)
- CNT_W, 8, width of the error counter
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- bit_valid  input  1  sample strobe; serial_in is consumed only in cycles where bit_valid=1
- serial_in  input  1  serial line, idle high
- clear_count  input  1  synchronous clear of err_count
- data_out  output  DATA_BITS  last received word, LSB received first
- frame_valid  output  1  one-cycle pulse: a complete frame was received
- parity_err  output  1  qualified by frame_valid: parity check failed
- frame_err  output  1  qualified by frame_valid: stop bit was 0
- err_count  output  CNT_W  frames with parity_err or frame_err, saturating
- busy  output  1  high in any state other than IDLE

## Operation
- Frame: start bit 0, DATA_BITS data bits LSB first, 1 parity bit, stop bit 1.
- State machine with registered state and transitions only on bit_valid=1:
  - IDLE: on serial_in=0, go to DATA and clear the bit index and running parity. On serial_in=1, stay.
  - DATA: shift serial_in into the shift register at position idx, XOR it into the running parity, and increment idx. After bit DATA_BITS-1, go to PARITY.
  - PARITY: set perr = (running_parity ^ serial_in) != ODD_PARITY, then go to STOP.
  - STOP: load data_out from the shift register, pulse frame_valid, set parity_err=perr and frame_err=~serial_in, then go to IDLE.
- A start bit is accepted in the cycle immediately after STOP, so back-to-back frames are supported.
- parity_err and frame_err may both be 1 in the same frame. Both are 0 whenever frame_valid=0.
- err_count increments by 1 per frame with parity_err|frame_err and holds at 2^CNT_W-1.
- clear_count sets err_count to 0. If clear_count and an increment occur in the same cycle, clear wins and the result is 0.
- data_out holds its value until the next completed frame.
- The frame is still delivered on a framing error. The consumer decides whether to discard it.

## Timing
- Reset values: state IDLE, data_out 0, frame_valid 0, parity_err 0, frame_err 0, err_count 0, busy 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately: no frame_valid is produced and err_count goes to 0.
- Latency: frame_valid, data_out, parity_err and frame_err are registered. They update on the clock edge that samples the stop bit and are visible for exactly one cycle.
- err_count updates on the same edge as frame_valid.
- bit_valid=0 freezes all state. A frame may span any number of cycles.
- busy goes high on the edge that samples the start bit. It goes low on the edge that samples the stop bit.
- frame_valid pulses are never adjacent, because a minimum frame is DATA_BITS+3 sampled bits.

## Test plan
- Even parity, DATA_BITS=8, bit_valid held at 1. Send 0xA5: bits 0, 1,0,1,0,0,1,0,1, then parity 0, then stop 1. Required: one frame_valid pulse with data_out=0xA5, parity_err=0, frame_err=0, err_count=0.
- Same frame 0xA5 with parity bit 1. Required: parity_err=1, err_count=1. Repeat with ODD_PARITY=1 and parity bit 1. Required: parity_err=0.
- 0x3C with correct parity and stop bit 0. Required: frame_err=1, data_out=0x3C, err_count increments. Then send a frame back-to-back starting the very next bit. Required: it is received correctly.
- bit_valid asserted 1 cycle in 4 while sending 0xFF. Required: result identical to the full-rate case, and busy stays high across all 11 sampled bits.
- Reset asserted after the 4th data bit. Required: busy=0 and no frame_valid. Then a full frame 0x01 is received correctly.
- CNT_W=2: send 5 bad frames. Required: err_count sticks at 3. Assert clear_count in the same cycle as a 6th bad frame's stop bit. Required: err_count=0.

Source files
------------

// File: rtl/serial_parity_frame_checker.sv
// Receive-side deframer for start/data/parity/stop serial frames.
// Presents each word with parity/framing status and keeps a saturating error count.
module serial_parity_frame_checker #(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_valid,
    input  logic                 serial_in,
    input  logic                 clear_count,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     err_count,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 perr_q;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 frame_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic [CNT_W-1:0]     err_count_q;
    logic [CNT_W-1:0]     err_count_d;
    logic                 stop_hit;
    logic                 bad_frame;

    // bit_valid is a sample strobe, not a handshake: serial_in is consumed only
    // when it is high, and there is no back-pressure toward the sender.
    always_comb begin
        stop_hit    = bit_valid && (state_q == S_STOP);
        bad_frame   = perr_q || !serial_in;
        err_count_d = err_count_q;
        if (clear_count) begin
            err_count_d = '0;
        end else if (stop_hit && bad_frame && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            perr_q        <= 1'b0;
            data_out_q    <= '0;
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            // Status outputs are single-cycle pulses regardless of bit_valid.
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= err_count_d;
            if (bit_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (!serial_in) begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                            par_q   <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        shift_q[idx_q] <= serial_in;
                        par_q          <= par_q ^ serial_in;
                        idx_q          <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        perr_q  <= (par_q ^ serial_in) != ODD_BIT;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        data_out_q    <= shift_q;
                        frame_valid_q <= 1'b1;
                        parity_err_q  <= perr_q;
                        frame_err_q   <= !serial_in;
                        state_q       <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out    = data_out_q;
    assign frame_valid = frame_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign err_count   = err_count_q;
    assign busy        = (state_q != S_IDLE);
    assign state_dbg   = state_q;

endmodule
